hiscore_ram_arbiter: RTL and testbench
======================================

# hiscore_ram_arbiter

Shares one game work-RAM port between the game CPU and the hiscore engine. The hiscore engine's `ram_access`/`ram_write` outputs drive the arbiter's request and write inputs. When the engine requests, the arbiter freezes the CPU at a bus-cycle boundary, waits for the address mux to settle, then hands the RAM port to the engine. A grant-length limit keeps the CPU from starving during long dumps. The block sits in the core top level between the CPU, the hiscore module and the work-RAM instance, and also owns the merged CPU pause output used by the OSD pause.

## Interface
Parameters:
- `AW`, 10: RAM address width.
- `SETTLE_CYCLES`, 4: cycles between CPU freeze and grant (mux settle); minimum 1.
- `RELEASE_CYCLES`, 2: cycles the CPU stays paused after the engine releases the port; minimum 1.
- `WAIT_TIMEOUT`, 255: maximum cycles spent waiting for `cpu_cycle_end` before forcing the freeze.
- `MAX_GRANT`, 1024: maximum continuous grant length in cycles; 0 disables the limit.
- `CPU_SLICE`, 64: cycles the CPU runs unpaused after a forced yield; minimum 1.

Ports:
- `clk`, in, 1: core clock.
- `reset`, in, 1: synchronous, active-low reset.
- `user_pause`, in, 1: OSD/system pause request.
- `cpu_cycle_end`, in, 1: one-cycle strobe at the end of each CPU bus cycle.
- `cpu_addr`, in, AW: CPU RAM address.
- `cpu_wr`, in, 1: CPU RAM write.
- `cpu_dout`, in, 8: CPU write data.
- `hs_access`, in, 1: hiscore engine request (level).
- `hs_write`, in, 1: hiscore engine write.
- `hs_addr`, in, AW: hiscore engine address.
- `hs_dout`, in, 8: hiscore engine write data.
- `cpu_pause`, out, 1: CPU clock-enable freeze.
- `hs_grant`, out, 1: the engine currently owns the port.
- `ram_addr`, out, AW: muxed RAM address.
- `ram_we`, out, 1: muxed RAM write.
- `ram_din`, out, 8: muxed RAM write data.

## Operation
- Registered state: `IDLE`, `REQ`, `SETTLE`, `GRANT`, `RELEASE`, `YIELD`.
- Internal register `sel` controls the port mux. The mux itself is combinational:
  - `ram_addr = sel ? hs_addr : cpu_addr`
  - `ram_we = sel ? (hs_write & hs_grant) : cpu_wr`
  - `ram_din = sel ? hs_dout : cpu_dout`
- `cpu_pause = arb_pause | user_pause`, where `arb_pause` is registered.
- State transitions:
  - **IDLE**: `hs_access=1` → REQ.
  - **REQ**: `arb_pause=1`.
    - If `cpu_cycle_end=1`, `user_pause=1`, or the wait counter reaches `WAIT_TIMEOUT-1` → SETTLE, wait counter cleared.
    - If `hs_access` drops → RELEASE.
  - **SETTLE**: counts `SETTLE_CYCLES` cycles, then → GRANT with `sel=1`, `hs_grant=1`. If `hs_access` drops during SETTLE → RELEASE.
  - **GRANT**: grant counter increments every cycle.
    - If `hs_access=0` → RELEASE with `sel=0`, `hs_grant=0`.
    - Otherwise, if `MAX_GRANT≠0` and the grant counter reaches `MAX_GRANT-1` → YIELD with `sel=0`, `hs_grant=0`, `arb_pause=0`.
  - **RELEASE**: `arb_pause` held for `RELEASE_CYCLES` cycles, then → IDLE with `arb_pause=0`.
  - **YIELD**: the CPU runs for `CPU_SLICE` cycles, then → REQ if `hs_access=1`, otherwise → IDLE. This repeats until the engine drops its request.
- Every state counter is cleared on entry to its state. Counters are sized to their parameter (`$clog2(param+1)`) and never wrap.
- Boundary cases:
  - `hs_write` asserted without a grant never reaches RAM.
  - `user_pause` never blocks or delays a grant; it only bypasses the boundary wait in REQ.
  - `cpu_cycle_end` in the same cycle as `hs_access` rising is ignored; the boundary is sampled only in REQ.
  - If `hs_access` drops and the grant limit is hit in the same GRANT cycle, RELEASE wins.

## Timing
- Reset (`reset=0` at a clock edge): next cycle state=IDLE, `arb_pause=0`, `sel=0`, `hs_grant=0`, all counters 0. Outputs are then:
  - `cpu_pause = user_pause`
  - `ram_we = cpu_wr`
  - `ram_addr = cpu_addr`
- Reset mid-GRANT drops `hs_grant` and `sel` in the same cycle.
- Request latency: with `hs_access` rising at edge N and `cpu_cycle_end` present at edge N+1, `arb_pause=1` from N+1 and `hs_grant=1` from N+2+SETTLE_CYCLES.
- Worst-case request latency: `1+WAIT_TIMEOUT+SETTLE_CYCLES` cycles.
- Release: `hs_access` falls at edge M → `hs_grant=0` and `sel=0` after M+1; `cpu_pause` falls after M+1+RELEASE_CYCLES (when `user_pause=0`).
- `hs_grant` and `sel` always change on the same edge, so the mux never drives engine data without a grant.

## Test plan
- Reset with `user_pause=0` and `cpu_wr=1` → `cpu_pause=0`, `hs_grant=0`, `ram_we=1`, `ram_addr=cpu_addr`.
- `hs_access` rises, `cpu_cycle_end` pulses 3 cycles later, `SETTLE_CYCLES=4` → `hs_grant` rises 8 cycles after the request. Engine write of 0x5A to 0x123 appears on `ram_addr`/`ram_din` with `ram_we=1`.
- No `cpu_cycle_end` with `WAIT_TIMEOUT=255` → grant forced after the timeout plus settle cycles; `cpu_pause` continuous throughout.
- `MAX_GRANT=16`, `CPU_SLICE=8`, `hs_access` held high → grant of 16 cycles, 8 unpaused cycles, then re-request. The cycle repeats until `hs_access` drops.
- `hs_access` drops during SETTLE, and separately during GRANT → no grant (or grant dropped next edge); `cpu_pause` released after `RELEASE_CYCLES`.
- `user_pause=1` held → `cpu_pause=1` always; a request reaches GRANT without `cpu_cycle_end`. Reset mid-GRANT → `hs_grant=0` and `ram_we=cpu_wr` the next cycle.

Source files
------------

// File: rtl/hiscore_ram_arbiter.sv
// hiscore_ram_arbiter: shares the work-RAM port between the game CPU and the hiscore engine
module hiscore_ram_arbiter #(
  parameter int AW             = 10,
  parameter int SETTLE_CYCLES  = 4,
  parameter int RELEASE_CYCLES = 2,
  parameter int WAIT_TIMEOUT   = 255,
  parameter int MAX_GRANT      = 1024,
  parameter int CPU_SLICE      = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          user_pause,
  input  logic          cpu_cycle_end,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_wr,
  input  logic [7:0]    cpu_dout,
  input  logic          hs_access,
  input  logic          hs_write,
  input  logic [AW-1:0] hs_addr,
  input  logic [7:0]    hs_dout,
  output logic          cpu_pause,
  output logic          hs_grant,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_din
);
  localparam int WW = $clog2(WAIT_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam int GW = MAX_GRANT > 0 ? $clog2(MAX_GRANT + 1) : 1;
  localparam int YW = $clog2(CPU_SLICE + 1);
  typedef enum logic [2:0] {IDLE, REQ, SETTLE, GRANT, RELEASE, YIELD} state_t;
  state_t state, state_n;
  logic sel, sel_n, grant_n, arb_pause, pause_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic [SW-1:0] settle_cnt, settle_n;
  logic [GW-1:0] grant_cnt, grant_cnt_n;
  logic [RW-1:0] rel_cnt, rel_n;
  logic [YW-1:0] slice_cnt, slice_n;
  assign ram_addr  = sel ? hs_addr : cpu_addr;
  assign ram_we    = sel ? (hs_write & hs_grant) : cpu_wr;
  assign ram_din   = sel ? hs_dout : cpu_dout;
  assign cpu_pause = arb_pause | user_pause;
  always_ff @(posedge clk)
    if (!reset) begin
      state      <= IDLE;
      sel        <= 1'b0;
      hs_grant   <= 1'b0;
      arb_pause  <= 1'b0;
      wait_cnt   <= '0;
      settle_cnt <= '0;
      grant_cnt  <= '0;
      rel_cnt    <= '0;
      slice_cnt  <= '0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      hs_grant   <= grant_n;
      arb_pause  <= pause_n;
      wait_cnt   <= wait_n;
      settle_cnt <= settle_n;
      grant_cnt  <= grant_cnt_n;
      rel_cnt    <= rel_n;
      slice_cnt  <= slice_n;
    end
  // counters idle at zero outside their own state, so each starts cleared on entry
  always_comb begin
    state_n     = state;
    sel_n       = sel;
    grant_n     = hs_grant;
    pause_n     = arb_pause;
    wait_n      = '0;
    settle_n    = '0;
    grant_cnt_n = '0;
    rel_n       = '0;
    slice_n     = '0;
    case (state)
      IDLE: if (hs_access) state_n = REQ;
      REQ: begin
        pause_n = 1'b1;
        if (!hs_access) state_n = RELEASE;
        else if (cpu_cycle_end || user_pause || wait_cnt == WW'(WAIT_TIMEOUT - 1)) state_n = SETTLE;
        else wait_n = wait_cnt + 1'b1;
      end
      SETTLE: begin
        if (!hs_access) state_n = RELEASE;
        else if (settle_cnt == SW'(SETTLE_CYCLES)) begin
          state_n = GRANT;
          sel_n   = 1'b1;
          grant_n = 1'b1;
        end else settle_n = settle_cnt + 1'b1;
      end
      GRANT: begin
        if (!hs_access) begin
          state_n = RELEASE;
          sel_n   = 1'b0;
          grant_n = 1'b0;
        end else if (MAX_GRANT != 0 && grant_cnt == GW'(MAX_GRANT - 1)) begin
          state_n = YIELD;
          sel_n   = 1'b0;
          grant_n = 1'b0;
          pause_n = 1'b0;
        end else grant_cnt_n = &grant_cnt ? grant_cnt : grant_cnt + 1'b1;
      end
      RELEASE: begin
        if (rel_cnt == RW'(RELEASE_CYCLES)) begin
          state_n = IDLE;
          pause_n = 1'b0;
        end else rel_n = rel_cnt + 1'b1;
      end
      YIELD: begin
        // re-pause on the way out so the CPU gets exactly CPU_SLICE free cycles
        if (slice_cnt == YW'(CPU_SLICE - 1)) begin
          state_n = hs_access ? REQ : IDLE;
          pause_n = hs_access;
        end else slice_n = slice_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// tb_hiscore_ram_arbiter: scenario bench with an event scoreboard for hiscore_ram_arbiter
module tb_hiscore_ram_arbiter;
  localparam int AW = 10;
  logic clk = 0, reset = 0, user_pause = 0, cpu_cycle_end = 0, cpu_wr = 0;
  logic hs_access = 0, hs_write = 0;
  logic [AW-1:0] cpu_addr = '0, hs_addr = '0;
  logic [7:0] cpu_dout = '0, hs_dout = '0;
  logic cpu_pause, hs_grant, ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0] ram_din;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {int kind; int at;} ev_t;
  ev_t exp_q[$];

  hiscore_ram_arbiter #(.AW(AW), .SETTLE_CYCLES(4), .RELEASE_CYCLES(2), .WAIT_TIMEOUT(255),
                        .MAX_GRANT(16), .CPU_SLICE(8)) dut (
    .clk(clk), .reset(reset), .user_pause(user_pause), .cpu_cycle_end(cpu_cycle_end),
    .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout), .hs_access(hs_access),
    .hs_write(hs_write), .hs_addr(hs_addr), .hs_dout(hs_dout), .cpu_pause(cpu_pause),
    .hs_grant(hs_grant), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 0; user_pause = 0; cpu_wr = 1; cpu_addr = 10'h2AA;
    tick(3);
    tests++; if (cpu_pause !== 1'b0) begin fails++; $display("FAIL reset_pause: got %b want 0", cpu_pause); end
    tests++; if (hs_grant !== 1'b0) begin fails++; $display("FAIL reset_grant: got %b want 0", hs_grant); end
    tests++; if (ram_we !== 1'b1) begin fails++; $display("FAIL reset_we: got %b want 1", ram_we); end
    tests++; if (ram_addr !== 10'h2AA) begin fails++; $display("FAIL reset_addr: got %h want 2aa", ram_addr); end
    user_pause = 1; #1;
    tests++; if (cpu_pause !== 1'b1) begin fails++; $display("FAIL reset_user_pause: got %b want 1", cpu_pause); end
    user_pause = 0; reset = 1;
    tick(2);
  endtask

  task automatic test_request;
    int n, m, at;
    ev_t ev;
    cpu_wr = 0; cpu_addr = 10'h055; hs_write = 1; hs_addr = 10'h123; hs_dout = 8'h5A;
    hs_access = 1; cpu_cycle_end = 1; n = cyc + 1;
    exp_q.push_back('{0, n + 8});
    tick; cpu_cycle_end = 0;
    tests++; if (cpu_pause !== 1'b0) begin fails++; $display("FAIL req_pause_early: got %b want 0", cpu_pause); end
    tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL req_ungranted_we: got %b want 0", ram_we); end
    tick;
    tests++; if (cpu_pause !== 1'b1) begin fails++; $display("FAIL req_pause: got %b want 1", cpu_pause); end
    tick; cpu_cycle_end = 1;
    tick; cpu_cycle_end = 0;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      if (hs_grant === 1'b1) begin at = cyc; break; end
      tick;
    end
    ev = exp_q.pop_front();
    tests++; if (at !== ev.at) begin fails++; $display("FAIL req_grant_cycle: got %0d want %0d", at, ev.at); end
    tests++; if (ram_addr !== 10'h123) begin fails++; $display("FAIL req_addr: got %h want 123", ram_addr); end
    tests++; if (ram_din !== 8'h5A) begin fails++; $display("FAIL req_din: got %h want 5a", ram_din); end
    tests++; if (ram_we !== 1'b1) begin fails++; $display("FAIL req_we: got %b want 1", ram_we); end
    hs_access = 0; m = cyc + 1;
    exp_q.push_back('{3, m + 3});
    tick;
    tests++; if (hs_grant !== 1'b0) begin fails++; $display("FAIL rel_grant: got %b want 0", hs_grant); end
    tests++; if (ram_addr !== 10'h055) begin fails++; $display("FAIL rel_addr: got %h want 055", ram_addr); end
    tests++; if (cpu_pause !== 1'b1) begin fails++; $display("FAIL rel_pause_held: got %b want 1", cpu_pause); end
    at = -1;
    for (int i = 0; i < 20; i++) begin
      if (cpu_pause === 1'b0) begin at = cyc; break; end
      tick;
    end
    ev = exp_q.pop_front();
    tests++; if (at !== ev.at) begin fails++; $display("FAIL rel_pause_cycle: got %0d want %0d", at, ev.at); end
    hs_write = 0;
    tick(2);
  endtask

  task automatic test_timeout;
    int n, at, gaps;
    ev_t ev;
    hs_access = 1; n = cyc + 1; at = -1; gaps = 0;
    exp_q.push_back('{0, n + 1 + 255 + 4});
    for (int i = 0; i < 400; i++) begin
      tick;
      if (hs_grant === 1'b1) begin at = cyc; break; end
      if (cyc >= n + 1 && cpu_pause !== 1'b1) gaps++;
    end
    ev = exp_q.pop_front();
    tests++; if (at !== ev.at) begin fails++; $display("FAIL timeout_grant_cycle: got %0d want %0d", at, ev.at); end
    tests++; if (gaps !== 0) begin fails++; $display("FAIL timeout_pause_gaps: got %0d want 0", gaps); end
    hs_access = 0;
    tick(5);
    tests++; if (cpu_pause !== 1'b0) begin fails++; $display("FAIL timeout_idle_pause: got %b want 0", cpu_pause); end
  endtask

  task automatic test_grant_limit;
    int n, bad;
    logic pg, pp;
    ev_t ev;
    cpu_wr = 0; hs_write = 1; cpu_cycle_end = 1; hs_access = 1; n = cyc + 1; bad = 0;
    exp_q.push_back('{2, n + 1});  exp_q.push_back('{0, n + 6});
    exp_q.push_back('{1, n + 22}); exp_q.push_back('{3, n + 22});
    exp_q.push_back('{2, n + 30}); exp_q.push_back('{0, n + 36});
    exp_q.push_back('{1, n + 52}); exp_q.push_back('{3, n + 52});
    exp_q.push_back('{2, n + 60}); exp_q.push_back('{0, n + 66});
    exp_q.push_back('{1, n + 67}); exp_q.push_back('{3, n + 70});
    pg = hs_grant; pp = cpu_pause;
    while (cyc < n + 75) begin
      tick;
      if (cyc == n + 66) hs_access = 0;
      if (hs_grant !== pg) begin
        ev = exp_q.size() > 0 ? exp_q.pop_front() : '{-1, -1};
        tests++;
        if (ev.kind !== (hs_grant ? 0 : 1) || ev.at !== cyc) begin
          fails++; $display("FAIL limit_grant_edge: got kind %0d at %0d want kind %0d at %0d", hs_grant ? 0 : 1, cyc, ev.kind, ev.at);
        end
      end
      if (cpu_pause !== pp) begin
        ev = exp_q.size() > 0 ? exp_q.pop_front() : '{-1, -1};
        tests++;
        if (ev.kind !== (cpu_pause ? 2 : 3) || ev.at !== cyc) begin
          fails++; $display("FAIL limit_pause_edge: got kind %0d at %0d want kind %0d at %0d", cpu_pause ? 2 : 3, cyc, ev.kind, ev.at);
        end
      end
      if (ram_we !== hs_grant) bad++;
      pg = hs_grant; pp = cpu_pause;
    end
    tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL limit_missing_events: got %0d left want 0", exp_q.size()); exp_q.delete(); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL limit_we_gating: got %0d bad cycles want 0", bad); end
    hs_write = 0; cpu_cycle_end = 0;
    tick(2);
  endtask

  task automatic test_drop_settle;
    int n, at;
    logic granted;
    ev_t ev;
    hs_access = 1; cpu_cycle_end = 1; n = cyc + 1; at = -1; granted = 0;
    tick; tick; cpu_cycle_end = 0;
    tick; hs_access = 0;
    exp_q.push_back('{3, n + 6});
    for (int i = 0; i < 20; i++) begin
      tick;
      if (hs_grant === 1'b1) granted = 1;
      if (cpu_pause === 1'b0) begin at = cyc; break; end
    end
    ev = exp_q.pop_front();
    tests++; if (granted !== 1'b0) begin fails++; $display("FAIL settle_drop_grant: got %b want 0", granted); end
    tests++; if (at !== ev.at) begin fails++; $display("FAIL settle_drop_pause_cycle: got %0d want %0d", at, ev.at); end
    tick(2);
  endtask

  task automatic test_user_pause;
    int n, at, gaps;
    ev_t ev;
    user_pause = 1; hs_access = 1; hs_write = 1; cpu_wr = 1; cpu_addr = 10'h3C3;
    n = cyc + 1; at = -1; gaps = 0;
    exp_q.push_back('{0, n + 6});
    for (int i = 0; i < 40; i++) begin
      tick;
      if (cpu_pause !== 1'b1) gaps++;
      if (hs_grant === 1'b1) begin at = cyc; break; end
    end
    ev = exp_q.pop_front();
    tests++; if (at !== ev.at) begin fails++; $display("FAIL upause_grant_cycle: got %0d want %0d", at, ev.at); end
    tests++; if (gaps !== 0) begin fails++; $display("FAIL upause_pause_gaps: got %0d want 0", gaps); end
    hs_write = 0; #1;
    tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL upause_hs_we: got %b want 0", ram_we); end
    reset = 0;
    tick;
    tests++; if (hs_grant !== 1'b0) begin fails++; $display("FAIL rst_grant: got %b want 0", hs_grant); end
    tests++; if (ram_we !== 1'b1) begin fails++; $display("FAIL rst_we: got %b want 1", ram_we); end
    tests++; if (ram_addr !== 10'h3C3) begin fails++; $display("FAIL rst_addr: got %h want 3c3", ram_addr); end
    tests++; if (cpu_pause !== 1'b1) begin fails++; $display("FAIL rst_user_pause: got %b want 1", cpu_pause); end
    user_pause = 0; #1;
    tests++; if (cpu_pause !== 1'b0) begin fails++; $display("FAIL rst_arb_pause: got %b want 0", cpu_pause); end
    hs_access = 0; reset = 1;
    tick(2);
  endtask

  initial begin
    test_reset;
    test_request;
    test_timeout;
    test_grant_limit;
    test_drop_settle;
    test_user_pause;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
